// File: rtl/nidhogg_pkg.sv
// Shared definitions for the nidhogg VGA game pipeline: player FSM encoding and screen geometry.
package nidhogg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WALK = 2'b01,
        ST_JUMP = 2'b10
    } state_t;

    localparam int unsigned SPRITE_W = 64;
    localparam int unsigned SPRITE_H = 64;
    localparam int unsigned SCREEN_W = 1024;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Button/vblank inputs and per-frame sprite outputs of the player motion controller.
interface player_motion_ctrl_if;

    logic        left;
    logic        right;
    logic        jump;
    logic        vblnk_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        legs_sel;
    logic        facing_left;
    logic [1:0]  state;
    logic        frame_tick;

    modport master (
        output left, right, jump, vblnk_in,
        input  xpos, ypos, legs_sel, facing_left, state, frame_tick
    );

    modport slave (
        input  left, right, jump, vblnk_in,
        output xpos, ypos, legs_sel, facing_left, state, frame_tick
    );

endinterface

// File: rtl/sync_2ff.sv
// Parameterizable 2-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player sprite motion/animation controller, updated once per vblank rise.
// Optional jump physics enabled by defining PLAYER_CTRL_JUMP_EN.
module player_motion_ctrl
    import nidhogg_pkg::*;
#(
    parameter int unsigned X_INIT   = 75,
    parameter int unsigned Y_GROUND = 600,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 960,
    parameter int unsigned STEP     = 4,
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned JUMP_V0  = 12,
    parameter int unsigned GRAVITY  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    player_motion_ctrl_if.slave  bus
);

    localparam int unsigned AW = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

    logic        w_left;
    logic        w_right;
    logic        w_jump;
    logic        w_tick;
    logic        w_go_r;
    logic        w_go_l;
    logic [12:0] w_x_inc;
    logic signed [12:0] w_x_dec;

    logic          r_vblnk_d;
    logic          r_frame_tick;
    logic [11:0]   r_xpos;
    logic          r_legs_sel;
    logic          r_facing_left;
    logic [AW-1:0] r_anim;
    state_t        r_state;

`ifdef PLAYER_CTRL_JUMP_EN
    logic [11:0]        r_ypos;
    logic signed [7:0]  r_vy;
    logic signed [12:0] w_y_next;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.left, bus.right, bus.jump}),
        .o_q   ({w_left, w_right, w_jump})
    );

    assign w_y_next = $signed({1'b0, r_ypos}) - $signed({{5{r_vy[7]}}, r_vy});
    assign bus.ypos = r_ypos;
`else
    logic w_unused_jump;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.left, bus.right}),
        .o_q   ({w_left, w_right})
    );

    assign w_jump        = 1'b0;
    assign w_unused_jump = bus.jump;
    assign bus.ypos      = 12'(Y_GROUND);
`endif

    assign w_tick  = bus.vblnk_in & ~r_vblnk_d;
    assign w_go_r  = w_right & ~w_left;
    assign w_go_l  = w_left & ~w_right;
    assign w_x_inc = {1'b0, r_xpos} + 13'(STEP);
    // Signed 13-bit subtract so a step past X_MIN never wraps to a large unsigned value
    assign w_x_dec = $signed({1'b0, r_xpos}) - $signed(13'(STEP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vblnk_d     <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_xpos        <= 12'(X_INIT);
            r_legs_sel    <= 1'b0;
            r_facing_left <= 1'b0;
            r_anim        <= '0;
            r_state       <= ST_IDLE;
`ifdef PLAYER_CTRL_JUMP_EN
            r_ypos        <= 12'(Y_GROUND);
            r_vy          <= '0;
`endif
        end else begin
            r_vblnk_d    <= bus.vblnk_in;
            r_frame_tick <= w_tick;
            if (w_tick) begin
                if (w_go_r) begin
                    r_xpos        <= (w_x_inc > 13'(X_MAX)) ? 12'(X_MAX) : w_x_inc[11:0];
                    r_facing_left <= 1'b0;
                end else if (w_go_l) begin
                    r_xpos        <= (w_x_dec < $signed(13'(X_MIN))) ? 12'(X_MIN) : w_x_dec[11:0];
                    r_facing_left <= 1'b1;
                end

                case (r_state)
                    ST_IDLE, ST_WALK: begin
                        if (w_jump) begin
                            r_state <= ST_JUMP;
`ifdef PLAYER_CTRL_JUMP_EN
                            r_vy    <= 8'(JUMP_V0);
`endif
                        end else if (w_go_r | w_go_l) begin
                            r_state <= ST_WALK;
                            if (r_anim == AW'(ANIM_DIV - 1)) begin
                                r_anim     <= '0;
                                r_legs_sel <= ~r_legs_sel;
                            end else begin
                                r_anim <= r_anim + 1'b1;
                            end
                        end else begin
                            r_state    <= ST_IDLE;
                            r_anim     <= '0;
                            r_legs_sel <= 1'b0;
                        end
                    end
`ifdef PLAYER_CTRL_JUMP_EN
                    ST_JUMP: begin
                        if (w_y_next >= $signed(13'(Y_GROUND))) begin
                            r_ypos     <= 12'(Y_GROUND);
                            r_vy       <= '0;
                            r_state    <= ST_IDLE;
                            r_anim     <= '0;
                            r_legs_sel <= 1'b0;
                        end else begin
                            r_ypos <= (w_y_next < 0) ? 12'd0 : w_y_next[11:0];
                            r_vy   <= r_vy - 8'(GRAVITY);
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.xpos        = r_xpos;
    assign bus.legs_sel    = r_legs_sel;
    assign bus.facing_left = r_facing_left;
    assign bus.state       = r_state;
    assign bus.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed self-checking bench for player_motion_ctrl (both jump-enabled and default builds).
module tb_player_motion_ctrl;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [11:0] pre_x;
    logic        pre_tick;
    logic        post_tick;
    logic        after_tick;

    player_motion_ctrl_if bus ();

    player_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset        = 1'b1;
        bus.left     = 1'b0;
        bus.right    = 1'b0;
        bus.jump     = 1'b0;
        bus.vblnk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One video frame; returns #1 after the update edge. pre_x/pre_tick sampled before that edge.
    task automatic frame();
        bus.vblnk_in = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.vblnk_in = 1'b1;
        #2;
        pre_x    = bus.xpos;
        pre_tick = bus.frame_tick;
        @(posedge clk);
        #1 post_tick = bus.frame_tick;
        @(posedge clk);
        #1 after_tick = bus.frame_tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.xpos !== 12'd75 || bus.ypos !== 12'd600 || bus.state !== 2'b00 ||
            bus.legs_sel !== 1'b0 || bus.facing_left !== 1'b0 || bus.frame_tick !== 1'b0)
            $display("FAIL reset_values: got x=%0d y=%0d st=%b legs=%b fl=%b tick=%b, required 75 600 00 0 0 0",
                     bus.xpos, bus.ypos, bus.state, bus.legs_sel, bus.facing_left, bus.frame_tick);
        else n_pass++;
        for (int f = 0; f < 3; f++) begin
            frame();
            n_total++;
            if (pre_tick !== 1'b0 || post_tick !== 1'b1 || after_tick !== 1'b0)
                $display("FAIL idle_tick_pulse f%0d: got %b%b%b, required 010", f, pre_tick,
                         post_tick, after_tick);
            else n_pass++;
            n_total++;
            if (bus.xpos !== 12'd75 || bus.ypos !== 12'd600 || bus.state !== 2'b00 ||
                bus.legs_sel !== 1'b0)
                $display("FAIL idle_hold f%0d: got x=%0d y=%0d st=%b legs=%b, required 75 600 00 0",
                         f, bus.xpos, bus.ypos, bus.state, bus.legs_sel);
            else n_pass++;
        end
    endtask

    task automatic test_walk_right();
        logic [11:0] exp_x [3] = '{12'd79, 12'd83, 12'd87};
        logic [11:0] prev;
        do_reset();
        bus.right = 1'b1;
        prev = 12'd75;
        for (int f = 0; f < 3; f++) begin
            frame();
            n_total++;
            if (pre_x !== prev)
                $display("FAIL walk_pre_edge f%0d: got x=%0d, required %0d", f, pre_x, prev);
            else n_pass++;
            n_total++;
            if (bus.xpos !== exp_x[f] || bus.state !== 2'b01 || bus.facing_left !== 1'b0)
                $display("FAIL walk_right f%0d: got x=%0d st=%b fl=%b, required %0d 01 0", f,
                         bus.xpos, bus.state, bus.facing_left, exp_x[f]);
            else n_pass++;
            prev = exp_x[f];
        end
    endtask

    task automatic test_left_clamp();
        int ex;
        do_reset();
        bus.left = 1'b1;
        ex = 75;
        for (int f = 1; f <= 20; f++) begin
            frame();
            ex = (ex >= 4) ? ex - 4 : 0;
            n_total++;
            if (bus.xpos !== 12'(ex))
                $display("FAIL left_clamp tick%0d: got x=%0d, required %0d", f, bus.xpos, ex);
            else n_pass++;
        end
        n_total++;
        if (bus.facing_left !== 1'b1 || bus.state !== 2'b01)
            $display("FAIL left_facing: got fl=%b st=%b, required 1 01", bus.facing_left,
                     bus.state);
        else n_pass++;
        bus.right = 1'b1;
        repeat (2) frame();
        n_total++;
        if (bus.xpos !== 12'd0 || bus.state !== 2'b00 || bus.facing_left !== 1'b1)
            $display("FAIL both_held: got x=%0d st=%b fl=%b, required 0 00 1", bus.xpos,
                     bus.state, bus.facing_left);
        else n_pass++;
    endtask

    task automatic test_anim();
        do_reset();
        bus.right = 1'b1;
        for (int f = 1; f <= 20; f++) begin
            frame();
            if (f == 7 || f == 8 || f == 15 || f == 16) begin
                n_total++;
                if (bus.legs_sel !== ((f == 8 || f == 15) ? 1'b1 : 1'b0))
                    $display("FAIL anim_toggle tick%0d: got legs=%b, required %b", f,
                             bus.legs_sel, (f == 8 || f == 15));
                else n_pass++;
            end
        end
        bus.right = 1'b0;
        frame();
        n_total++;
        if (bus.state !== 2'b00 || bus.legs_sel !== 1'b0)
            $display("FAIL anim_release: got st=%b legs=%b, required 00 0", bus.state,
                     bus.legs_sel);
        else n_pass++;
        // Counter was at 4 on release; it must restart from 0
        bus.right = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            frame();
            if (f == 4 || f == 8) begin
                n_total++;
                if (bus.legs_sel !== (f == 8))
                    $display("FAIL anim_restart tick%0d: got legs=%b, required %b", f,
                             bus.legs_sel, (f == 8));
                else n_pass++;
            end
        end
        // Reset mid-walk takes effect without a clock edge
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.xpos !== 12'd75 || bus.state !== 2'b00 || bus.legs_sel !== 1'b0)
            $display("FAIL reset_midwalk: got x=%0d st=%b legs=%b, required 75 00 0", bus.xpos,
                     bus.state, bus.legs_sel);
        else n_pass++;
        bus.right = 1'b0;
        #20 reset = 1'b0;
    endtask

`ifdef PLAYER_CTRL_JUMP_EN
    task automatic test_jump();
        int ey;
        int evy;
        do_reset();
        bus.jump = 1'b1;
        frame();
        bus.jump = 1'b0;
        n_total++;
        if (bus.state !== 2'b10 || bus.ypos !== 12'd600)
            $display("FAIL jump_entry: got st=%b y=%0d, required 10 600", bus.state, bus.ypos);
        else n_pass++;
        ey  = 600;
        evy = 12;
        for (int k = 1; k <= 25; k++) begin
            bus.right = (k <= 3);
            bus.jump  = (k == 5 || k == 6);
            frame();
            ey  = ey - evy;
            evy = evy - 1;
            n_total++;
            if (bus.ypos !== 12'(ey) || bus.state !== ((k < 25) ? 2'b10 : 2'b00))
                $display("FAIL jump_arc tick%0d: got y=%0d st=%b, required %0d %b", k, bus.ypos,
                         bus.state, ey, ((k < 25) ? 2'b10 : 2'b00));
            else n_pass++;
            if (k == 3) begin
                n_total++;
                if (bus.ypos !== 12'd567 || bus.xpos !== 12'd87)
                    $display("FAIL jump_air_move: got y=%0d x=%0d, required 567 87", bus.ypos,
                             bus.xpos);
                else n_pass++;
            end
        end
        bus.jump  = 1'b0;
        bus.right = 1'b0;
        frame();
        n_total++;
        if (bus.ypos !== 12'd600 || bus.state !== 2'b00 || bus.xpos !== 12'd87)
            $display("FAIL jump_landed: got y=%0d st=%b x=%0d, required 600 00 87", bus.ypos,
                     bus.state, bus.xpos);
        else n_pass++;
    endtask

    task automatic test_reset_midair();
        do_reset();
        bus.jump = 1'b1;
        frame();
        bus.jump = 1'b0;
        repeat (5) frame();
        n_total++;
        if (bus.ypos !== 12'd550 || bus.state !== 2'b10)
            $display("FAIL midair_pos: got y=%0d st=%b, required 550 10", bus.ypos, bus.state);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.ypos !== 12'd600 || bus.state !== 2'b00)
            $display("FAIL reset_midair: got y=%0d st=%b, required 600 00", bus.ypos, bus.state);
        else n_pass++;
        #20 reset = 1'b0;
        frame();
        n_total++;
        if (bus.ypos !== 12'd600 || bus.state !== 2'b00)
            $display("FAIL after_reset_air: got y=%0d st=%b, required 600 00", bus.ypos,
                     bus.state);
        else n_pass++;
    endtask
`else
    task automatic test_jump_disabled();
        do_reset();
        bus.jump = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame();
            n_total++;
            if (bus.state !== 2'b00 || bus.ypos !== 12'd600)
                $display("FAIL jump_disabled f%0d: got st=%b y=%0d, required 00 600", f,
                         bus.state, bus.ypos);
            else n_pass++;
        end
        bus.jump = 1'b0;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_walk_right();
        test_left_clamp();
        test_anim();
`ifdef PLAYER_CTRL_JUMP_EN
        test_jump();
        test_reset_midair();
`else
        test_jump_disabled();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Per-frame motion and animation controller for one player sprite in the VGA game pipeline. It samples the left, right and jump buttons once per video frame. It produces the sprite anchor position (xpos/ypos) and the legs-frame select consumed by the player draw stage. Head is drawn at ypos; legs at ypos+64 (draw stage's concern). Sits between the button debouncers and the player sprite renderer; all outputs are registered and stable for a whole frame.

Parameters:
X_INIT, 75, reset x position (pixels)
Y_GROUND, 600, ground-level y position (pixels)
X_MIN, 0, leftmost allowed xpos
X_MAX, 960, rightmost allowed xpos (1024 - sprite width 64)
STEP, 4, horizontal pixels moved per frame while walking
ANIM_DIV, 8, frames per legs-frame toggle while walking
JUMP_V0, 12, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity decrement per frame

Ports:
clk  in  1  pixel clock
reset  in  1  async active-high reset
left  in  1  left button, asynchronous level
right  in  1  right button, asynchronous level
jump  in  1  jump button, asynchronous level
vblnk_in  in  1  vertical blank from timing chain
xpos  out  12  sprite anchor x
ypos  out  12  sprite anchor y (head top)
legs_sel  out  1  0 = legs frame A, 1 = legs frame B
facing_left  out  1  1 = last horizontal move was left
state  out  2  00 IDLE, 01 WALK, 10 JUMP
frame_tick  out  1  one-cycle pulse, start of vblank

Behaviour:
- Reset: clock and reset are decided: reset reset, asynchronous, active-high; clock clk.
- Reset values: xpos=X_INIT, ypos=Y_GROUND, legs_sel=0, facing_left=0, state=IDLE, frame_tick=0. Internal vy=0, anim counter=0, synchronizers=0.
- left/right/jump each pass through a 2-flop synchronizer.
- frame_tick = vblnk_in & ~vblnk_d, where vblnk_d is vblnk_in registered. frame_tick output is that combinational term registered, i.e. high one cycle after the edge.
- All state/position updates occur only on the clock edge where the internal (unregistered) tick is 1. Outputs therefore change exactly 1 clk after vblnk_in rises and hold until the next frame.
- Horizontal intent: dir = R if right&~left, L if left&~right, none if both or neither.
  - R: xpos = min(xpos+STEP, X_MAX); facing_left=0.
  - L: xpos = max(xpos-STEP, X_MIN), computed without unsigned underflow (13-bit compare); facing_left=1.
  - Horizontal motion applies in all states, including JUMP.
- FSM transitions (evaluated at tick):
  - IDLE: jump -> JUMP (vy=JUMP_V0, ypos unchanged this tick); else dir≠none -> WALK; else stay.
  - WALK: jump -> JUMP; else dir=none -> IDLE; else stay.
  - JUMP: y_next = ypos - vy (13-bit signed); vy = vy - GRAVITY (8-bit signed).
    - If y_next >= Y_GROUND: ypos=Y_GROUND, vy=0, state=IDLE.
    - Else if y_next < 0: ypos=0.
    - Else ypos=y_next.
    - jump input ignored while in JUMP (no double jump).
- Animation:
  - In WALK, anim counter increments per tick; on reaching ANIM_DIV-1 it wraps to 0 and legs_sel toggles.
  - Entering IDLE clears the counter and legs_sel=0.
  - In JUMP, the counter and legs_sel hold.
- Reset asserted mid-jump or mid-walk: all registers return to reset values immediately (async).

Optional Feature:
PLAYER_CTRL_JUMP_EN
- Defined: JUMP state, vy register and vertical physics present as above.
- Undefined: jump input and its synchronizer removed; state never equals JUMP; ypos is constant Y_GROUND.

Decomposition:
- Shared package nidhogg_pkg: state encoding constants (ST_IDLE, ST_WALK, ST_JUMP), SPRITE_W=64, SPRITE_H=64, SCREEN_W=1024.
- One natural sub-module: sync_2ff (parameterizable 2-flop synchronizer, reused for all three buttons).

Test Plan:
- Reset release, no buttons, 3 frames -> xpos=75, ypos=600, state=IDLE, legs_sel=0, frame_tick pulses once per frame for exactly 1 clk.
- right held 3 frames -> xpos 79, 83, 87, each updating 1 clk after the vblnk rise; state=WALK; facing_left=0.
- left held 20 frames from 75 -> xpos reaches 3 after 18 ticks, then clamps to 0 on tick 19 and stays 0; facing_left=1. Both left+right held -> xpos frozen, state=IDLE.
- right held 16 frames -> legs_sel toggles at ticks 8 and 16; release -> state=IDLE, legs_sel=0.
- jump pulse from IDLE -> state=JUMP; subsequent ypos 588, 577, 567, ...; lands on 25th tick after entry with ypos=600, state=IDLE; jump pressed mid-air has no effect.
- reset asserted on the 5th air tick -> ypos=600, state=IDLE, vy=0 immediately, without waiting for a clock edge.
